wave_phase_gen: RTL and testbench

//  Per-channel oscillator front end. Drives the 9-bit phase address into a registered waveform LUT
//  (square/sine/saw, 512 entries, signed 16-bit out) and captures the returned sample.

---
 rtl/tracker_pkg.sv | 18 +
 rtl/osc_valid_pipe.sv | 29 ++
 rtl/wave_phase_gen.sv | 121 ++++++++++++
 tb/tb_wave_phase_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared oscillator types and default widths for the tracker channel blocks.
package tracker_pkg;

    localparam int OSC_ACC_W   = 24;
    localparam int OSC_ADDR_W  = 9;
    localparam int OSC_DATA_W  = 16;
    localparam int OSC_LUT_LAT = 1;

    // Increment that advances the LUT address by exactly one entry per tick
    localparam int INC_ONE_STEP = 1 << (OSC_ACC_W - OSC_ADDR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } osc_state_e;

endpackage

// File: rtl/osc_valid_pipe.sv
// Valid shift register that tracks outstanding LUT reads; flush discards them all.
module osc_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign tail = q[DEPTH-1];

endmodule

// File: rtl/wave_phase_gen.sv
// Per-channel phase accumulator and LUT request/capture front end.
//   state | meaning
//   IDLE  | no note; ticks ignored, sample_out parked at 0
//   START | note (re)triggered; next tick restarts phase at 0
//   RUN   | note playing; each tick issues a LUT request and steps the phase
module wave_phase_gen
    import tracker_pkg::*;
#(
    parameter int ACC_W   = OSC_ACC_W,
    parameter int ADDR_W  = OSC_ADDR_W,
    parameter int DATA_W  = OSC_DATA_W,
    parameter int LUT_LAT = OSC_LUT_LAT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_tick,
    input  logic                     note_on,
    input  logic                     note_off,
    input  logic                     inc_wr,
    input  logic        [ACC_W-1:0]  inc_in,
    output logic        [ADDR_W-1:0] addr_full,
    output logic                     addr_valid,
    input  logic signed [DATA_W-1:0] lut_data,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     active
);

    osc_state_e state, state_next;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_cur;
    logic [ACC_W-1:0] inc_pend;
    logic [ACC_W-1:0] inc_next;
    logic             flush;
    logic             start_tick;
    logic             run_tick;
    logic             pipe_tail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // note_on outranks note_off; a stopping note never issues a request
    always_comb begin
        state_next = state;
        flush      = note_off && !note_on;
        start_tick = 1'b0;
        run_tick   = 1'b0;
        case (state)
            IDLE: begin
                if (note_on) state_next = START;
            end
            START: begin
                start_tick = sample_tick && !flush;
                if (note_on)          state_next = START;
                else if (note_off)    state_next = IDLE;
                else if (sample_tick) state_next = RUN;
            end
            RUN: begin
                run_tick = sample_tick && !flush;
                if (note_on)       state_next = START;
                else if (note_off) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign inc_next = (start_tick || run_tick) ? inc_pend : inc_cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            inc_cur      <= '0;
            inc_pend     <= '0;
            addr_full    <= '0;
            addr_valid   <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            addr_valid   <= 1'b0;
            sample_valid <= 1'b0;
            inc_cur      <= inc_next;
            if (inc_wr) begin
                inc_pend <= inc_in;
            end
            if (start_tick) begin
                acc        <= inc_pend;
                addr_full  <= '0;
                addr_valid <= 1'b1;
            end else if (run_tick) begin
                addr_full  <= acc[ACC_W-1 -: ADDR_W];
                acc        <= acc + inc_pend;
                addr_valid <= 1'b1;
            end
            if (flush) begin
                sample_out <= '0;
            end else if (pipe_tail) begin
                sample_out   <= lut_data;
                sample_valid <= 1'b1;
            end
        end
    end

    osc_valid_pipe #(
        .DEPTH (LUT_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .din     (addr_valid),
        .tail    (pipe_tail)
    );

    assign active = (state != IDLE);

endmodule

// File: tb/tb_wave_phase_gen.sv
// Directed bench for wave_phase_gen with a registered square-wave LUT model.
module tb_wave_phase_gen;
    import tracker_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic               note_on = 1'b0;
    logic               note_off = 1'b0;
    logic               inc_wr = 1'b0;
    logic        [23:0] inc_in = '0;
    logic        [8:0]  addr_full;
    logic               addr_valid;
    logic signed [15:0] lut_data = '0;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        lut_data <= (addr_full < 9'd256) ? 16'sh7FFF : 16'sh8001;
    end

    wave_phase_gen #(
        .ACC_W   (24),
        .ADDR_W  (9),
        .DATA_W  (16),
        .LUT_LAT (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .note_on      (note_on),
        .note_off     (note_off),
        .inc_wr       (inc_wr),
        .inc_in       (inc_in),
        .addr_full    (addr_full),
        .addr_valid   (addr_valid),
        .lut_data     (lut_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active       (active)
    );

    // Drive one cycle of strobes; returns 1 time unit after the edge that sampled them.
    task automatic do_cycle(input logic t, input logic on, input logic off,
                            input logic wr, input logic [23:0] inc);
        sample_tick = t;
        note_on     = on;
        note_off    = off;
        inc_wr      = wr;
        inc_in      = inc;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        note_on     = 1'b0;
        note_off    = 1'b0;
        inc_wr      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_cycle(0, 0, 0, 0, 24'h0);
    endtask

    task automatic start_note(input logic [23:0] inc);
        do_reset();
        do_cycle(0, 0, 0, 1, inc);
        do_cycle(0, 1, 0, 0, 24'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({addr_full, addr_valid, sample_out, sample_valid, active} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0h av=%0b s=%0h sv=%0b act=%0b, want all 0",
                     addr_full, addr_valid, sample_out, sample_valid, active);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({addr_valid, active} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_tick: got av=%0b act=%0b, want 0 0", addr_valid, active);
        end
    endtask

    task automatic test_step_sweep();
        logic [8:0]         ea;
        logic signed [15:0] es;
        start_note(24'(INC_ONE_STEP));
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL sweep_active_start: got %0b want 1", active);
        end
        for (int k = 0; k < 600; k++) begin
            ea = 9'(k % 512);
            es = (ea < 9'd256) ? 16'sh7FFF : 16'sh8001;
            do_cycle(1, 0, 0, 0, 24'h0);
            checks++;
            if ({addr_valid, addr_full} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL sweep_addr k=%0d: got av=%0b addr=%0d want av=1 addr=%0d",
                         k, addr_valid, addr_full, ea);
            end
            do_cycle(0, 0, 0, 0, 24'h0);
            checks++;
            if ({addr_valid, sample_valid} !== 2'b00) begin
                errors++;
                $display("FAIL sweep_pulse_width k=%0d: got av=%0b sv=%0b want 0 0",
                         k, addr_valid, sample_valid);
            end
            do_cycle(0, 0, 0, 0, 24'h0);
            checks++;
            if ({sample_valid, sample_out} !== {1'b1, es}) begin
                errors++;
                $display("FAIL sweep_sample k=%0d: got sv=%0b s=%0h want sv=1 s=%0h",
                         k, sample_valid, sample_out, es);
            end
        end
    endtask

    task automatic test_half_cycle();
        logic [8:0]         ea;
        logic signed [15:0] es;
        start_note(24'h800000);
        for (int k = 0; k < 4; k++) begin
            ea = (k % 2 == 0) ? 9'd0 : 9'd256;
            es = (k % 2 == 0) ? 16'sh7FFF : 16'sh8001;
            do_cycle(1, 0, 0, 0, 24'h0);
            checks++;
            if ({addr_valid, addr_full} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL half_addr k=%0d: got av=%0b addr=%0d want 1 %0d",
                         k, addr_valid, addr_full, ea);
            end
            do_cycle(0, 0, 0, 0, 24'h0);
            checks++;
            if (sample_valid !== 1'b0) begin
                errors++;
                $display("FAIL half_early_valid k=%0d: got %0b want 0", k, sample_valid);
            end
            do_cycle(0, 0, 0, 0, 24'h0);
            checks++;
            if ({sample_valid, sample_out} !== {1'b1, es}) begin
                errors++;
                $display("FAIL half_sample k=%0d: got sv=%0b s=%0h want 1 %0h",
                         k, sample_valid, sample_out, es);
            end
        end
    endtask

    task automatic test_inc_change();
        int exp_a [6] = '{0, 1, 2, 3, 5, 7};
        start_note(24'h008000);
        for (int k = 0; k < 6; k++) begin
            do_cycle(1, 0, 0, (k == 2), 24'h010000);
            checks++;
            if ({addr_valid, addr_full} !== {1'b1, 9'(exp_a[k])}) begin
                errors++;
                $display("FAIL inc_change_addr k=%0d: got av=%0b addr=%0d want 1 %0d",
                         k, addr_valid, addr_full, exp_a[k]);
            end
            do_cycle(0, 0, 0, 0, 24'h0);
            do_cycle(0, 0, 0, 0, 24'h0);
        end
    endtask

    task automatic test_note_off();
        start_note(24'h008000);
        do_cycle(1, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(1, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 1, 0, 24'h0);
        checks++;
        if ({active, sample_out} !== 17'h0) begin
            errors++;
            $display("FAIL note_off_state: got act=%0b s=%0h want 0 0", active, sample_out);
        end
        do_cycle(0, 0, 0, 0, 24'h0);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL note_off_flush: got sv=%0b want 0", sample_valid);
        end
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({addr_valid, addr_full, active} !== {1'b0, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL note_off_tick_ignored: got av=%0b addr=%0d act=%0b want 0 1 0",
                     addr_valid, addr_full, active);
        end
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        checks++;
        if ({sample_valid, sample_out} !== 17'h0) begin
            errors++;
            $display("FAIL note_off_no_sample: got sv=%0b s=%0h want 0 0", sample_valid, sample_out);
        end
    endtask

    task automatic test_retrigger();
        start_note(24'h008000);
        for (int k = 0; k < 4; k++) begin
            do_cycle(1, 0, 0, 0, 24'h0);
            do_cycle(0, 0, 0, 0, 24'h0);
            do_cycle(0, 0, 0, 0, 24'h0);
        end
        do_cycle(0, 1, 1, 0, 24'h0);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL retrig_active: got %0b want 1", active);
        end
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({addr_valid, addr_full} !== {1'b1, 9'd0}) begin
            errors++;
            $display("FAIL retrig_addr0: got av=%0b addr=%0d want 1 0", addr_valid, addr_full);
        end
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({addr_valid, addr_full} !== {1'b1, 9'd1}) begin
            errors++;
            $display("FAIL retrig_addr1: got av=%0b addr=%0d want 1 1", addr_valid, addr_full);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]         ea;
        logic signed [15:0] es;
        start_note(24'h400000);
        for (int i = 0; i < 6; i++) begin
            do_cycle((i < 4), 0, 0, 0, 24'h0);
            ea = 9'((i % 4) * 128);
            checks++;
            if (addr_valid !== (i < 4) || (i < 4 && addr_full !== ea)) begin
                errors++;
                $display("FAIL b2b_addr i=%0d: got av=%0b addr=%0d want av=%0b addr=%0d",
                         i, addr_valid, addr_full, (i < 4), ea);
            end
            if (i >= 2) begin
                es = (i < 4) ? 16'sh7FFF : 16'sh8001;
                checks++;
                if ({sample_valid, sample_out} !== {1'b1, es}) begin
                    errors++;
                    $display("FAIL b2b_sample i=%0d: got sv=%0b s=%0h want 1 %0h",
                             i, sample_valid, sample_out, es);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        start_note(24'h008000);
        do_cycle(1, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(1, 0, 0, 0, 24'h0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({addr_full, addr_valid, sample_out, sample_valid, active} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got addr=%0h av=%0b s=%0h sv=%0b act=%0b, want all 0",
                     addr_full, addr_valid, sample_out, sample_valid, active);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(1, 0, 0, 0, 24'h0);
        checks++;
        if ({addr_valid, active} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_idle: got av=%0b act=%0b want 0 0", addr_valid, active);
        end
        do_cycle(0, 0, 0, 0, 24'h0);
        do_cycle(0, 0, 0, 0, 24'h0);
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_no_sample: got sv=%0b want 0", sample_valid);
        end
    endtask

    initial begin
        test_reset();
        test_step_sweep();
        test_half_cycle();
        test_inc_change();
        test_note_off();
        test_retrigger();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
